// File: rtl/monitor_contador.sv
// Sequence monitor for the 4-bit bouncing up/down counter stream. It locks onto the
// triangle 0..MAXV..0 and reports direction, peak/valley pulses, periods and errors.
module monitor_contador #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERRW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             amostra_valida,
  input  logic [WIDTH-1:0] amostra,
  output logic             travado,
  output logic             direcao,
  output logic             pico,
  output logic             vale,
  output logic             erro,
  output logic [15:0]      ciclos,
  output logic [ERRW-1:0]  erros
);

  localparam logic [WIDTH-1:0] MAXV     = '1;
  localparam logic [WIDTH-1:0] MINV     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [ERRW-1:0]  ERR_SAT  = '1;
  localparam logic             DIR_UP   = 1'b0;
  localparam logic             DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       count_q;
  logic             last_dir_q;
  logic             travado_q;
  logic             direcao_q;
  logic             pico_q;
  logic             vale_q;
  logic             erro_q;
  logic [15:0]      ciclos_q;
  logic [ERRW-1:0]  erros_q;

  logic             at_endpoint;
  logic             step_up;
  logic             step_down;
  logic             step_legal;
  logic             step_dir;
  logic             step_consistent;
  logic [3:0]       count_d;
  logic             lock_d;
  logic [WIDTH-1:0] expected_d;
  logic             exp_dir_d;
  logic             match_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    count_d    = '0;
    expected_d = '0;
    exp_dir_d  = DIR_UP;

    // A legal step moves by exactly one without wrapping through the endpoints.
    at_endpoint     = (prev_q == MAXV) || (prev_q == MINV);
    step_up         = (prev_q != MAXV) && (amostra == prev_q + ONE);
    step_down       = (prev_q != MINV) && (amostra == prev_q - ONE);
    step_legal      = step_up || step_down;
    step_dir        = step_down ? DIR_DOWN : DIR_UP;
    step_consistent = step_legal && ((step_dir == last_dir_q) || at_endpoint);

    if (!step_legal) begin
      count_d = '0;
    end else if (step_consistent) begin
      count_d = (count_q == 4'hF) ? count_q : count_q + 4'd1;
    end else begin
      count_d = 4'd1;
    end
    lock_d = step_legal && (count_d >= LOCK_N);

    // While locked, the next sample is fully predicted, including the bounce.
    if (direcao_q == DIR_UP) begin
      if (prev_q == MAXV) begin
        expected_d = MAXV - ONE;
        exp_dir_d  = DIR_DOWN;
      end else begin
        expected_d = prev_q + ONE;
        exp_dir_d  = DIR_UP;
      end
    end else begin
      if (prev_q == MINV) begin
        expected_d = MINV + ONE;
        exp_dir_d  = DIR_UP;
      end else begin
        expected_d = prev_q - ONE;
        exp_dir_d  = DIR_DOWN;
      end
    end
    match_d = (amostra == expected_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      count_q    <= '0;
      last_dir_q <= DIR_UP;
      travado_q  <= 1'b0;
      direcao_q  <= DIR_UP;
      pico_q     <= 1'b0;
      vale_q     <= 1'b0;
      erro_q     <= 1'b0;
      ciclos_q   <= '0;
      erros_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      pico_q <= 1'b0;
      vale_q <= 1'b0;
      erro_q <= 1'b0;

      if (amostra_valida) begin
        case (state_q)
          IDLE: begin
            prev_q  <= amostra;
            count_q <= '0;
            state_q <= SYNC;
          end

          SYNC: begin
            prev_q  <= amostra;
            count_q <= count_d;
            if (step_legal) begin
              last_dir_q <= step_dir;
            end
            if (lock_d) begin
              state_q   <= LOCKED;
              travado_q <= 1'b1;
              direcao_q <= step_dir;
            end
          end

          LOCKED: begin
            prev_q <= amostra;
            if (match_d) begin
              direcao_q  <= exp_dir_d;
              last_dir_q <= exp_dir_d;
              pico_q     <= (amostra == MAXV);
              vale_q     <= (amostra == MINV);
              if (amostra == MINV) begin
                ciclos_q <= ciclos_q + 16'd1;
              end
            end else begin
              // Any deviation drops lock; relocking needs a fresh run of steps.
              erro_q    <= 1'b1;
              travado_q <= 1'b0;
              count_q   <= '0;
              state_q   <= SYNC;
              if (erros_q != ERR_SAT) begin
                erros_q <= erros_q + ERRW'(1);
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign travado = travado_q;
  assign direcao = direcao_q;
  assign pico    = pico_q;
  assign vale    = vale_q;
  assign erro    = erro_q;
  assign ciclos  = ciclos_q;
  assign erros   = erros_q;

endmodule

// File: tb/tb_monitor_contador.sv
// Bench for monitor_contador: table-driven vectors fed through a scoreboard queue, plus
// hand-written reset sequences. A second instance with ERRW=2 checks error saturation.
module tb_monitor_contador;

  logic        clk = 1'b0;
  logic        reset;
  logic        amostra_valida;
  logic [3:0]  amostra;

  logic        travado, direcao, pico, vale, erro;
  logic [15:0] ciclos;
  logic [7:0]  erros;
  logic        travado2, direcao2, pico2, vale2, erro2;
  logic [15:0] ciclos2;
  logic [1:0]  erros2;

  monitor_contador #(.WIDTH(4), .LOCK_COUNT(3), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .amostra_valida(amostra_valida), .amostra(amostra),
    .travado(travado), .direcao(direcao), .pico(pico), .vale(vale), .erro(erro),
    .ciclos(ciclos), .erros(erros)
  );

  monitor_contador #(.WIDTH(4), .LOCK_COUNT(3), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset), .amostra_valida(amostra_valida), .amostra(amostra),
    .travado(travado2), .direcao(direcao2), .pico(pico2), .vale(vale2), .erro(erro2),
    .ciclos(ciclos2), .erros(erros2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [3:0]  v;
    logic        trav;
    logic        dir;
    logic        pico;
    logic        vale;
    logic        erro;
    logic [15:0] ciclos;
    logic [7:0]  erros;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int valid, input int v, input int trav, input int dir,
                     input int pk, input int vl, input int er, input int cic, input int ers);
    vec_t r;
    r.valid  = (valid != 0);
    r.v      = 4'(v);
    r.trav   = (trav != 0);
    r.dir    = (dir != 0);
    r.pico   = (pk != 0);
    r.vale   = (vl != 0);
    r.erro   = (er != 0);
    r.ciclos = 16'(cic);
    r.erros  = 8'(ers);
    vecs.push_back(r);
  endtask

  task automatic compare(input string tag, input int idx);
    vec_t e;
    string n;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s[%0d]: scoreboard empty, got outputs with nothing expected", tag, idx);
      return;
    end
    e = sb.pop_front();
    n = $sformatf("%s[%0d]", tag, idx);
    check({n, ".travado"}, 32'(travado), 32'(e.trav));
    check({n, ".direcao"}, 32'(direcao), 32'(e.dir));
    check({n, ".pico"},    32'(pico),    32'(e.pico));
    check({n, ".vale"},    32'(vale),    32'(e.vale));
    check({n, ".erro"},    32'(erro),    32'(e.erro));
    check({n, ".ciclos"},  32'(ciclos),  32'(e.ciclos));
    check({n, ".erros"},   32'(erros),   32'(e.erros));
    check({n, ".erros_w2"}, 32'(erros2), (e.erros > 8'd3) ? 32'd3 : 32'(e.erros));
  endtask

  // Called at a negedge: drive, let the posedge accept, compare at the next negedge.
  task automatic run_vecs(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      amostra_valida = vecs[i].valid;
      amostra        = vecs[i].valid ? vecs[i].v : 4'($urandom_range(0, 15));
      sb.push_back(vecs[i]);
      @(negedge clk);
      compare(tag, i);
    end
    vecs.delete();
    amostra_valida = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".travado"}, 32'(travado), 32'd0);
    check({tag, ".direcao"}, 32'(direcao), 32'd0);
    check({tag, ".pico"},    32'(pico),    32'd0);
    check({tag, ".vale"},    32'(vale),    32'd0);
    check({tag, ".erro"},    32'(erro),    32'd0);
    check({tag, ".ciclos"},  32'(ciclos),  32'd0);
    check({tag, ".erros"},   32'(erros),   32'd0);
    check({tag, ".travado_w2"}, 32'(travado2), 32'd0);
    check({tag, ".erros_w2"},   32'(erros2),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v;
    reset          = 1'b1;
    amostra_valida = 1'b0;
    amostra        = '0;
    #2 reset = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    reset = 1'b1;

    // Full period from reset: lock after sample 3, peak at 15, valley at the final 0.
    for (int i = 0; i < 32; i++) begin
      v = (i <= 15) ? i : ((i <= 30) ? 30 - i : 1);
      add(1, v, (i >= 3) ? 1 : 0, (i >= 16 && i <= 30) ? 1 : 0,
          (i == 15) ? 1 : 0, (i == 30) ? 1 : 0, 0, (i >= 30) ? 1 : 0, 0);
    end
    run_vecs("period1");

    // Three more locked periods, bringing ciclos to 4.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 30; k++) begin
        v = (k <= 13) ? k + 2 : ((k <= 28) ? 28 - k : 1);
        add(1, v, 1, (k >= 14 && k <= 28) ? 1 : 0, (k == 13) ? 1 : 0, (k == 28) ? 1 : 0,
            0, 1 + p + ((k >= 28) ? 1 : 0), 0);
      end
    end
    run_vecs("periods2to4");
    check("pre_reset.ciclos", 32'(ciclos), 32'd4);
    check("pre_reset.travado", 32'(travado), 32'd1);

    // Asynchronous reset mid-cycle while locked: outputs clear before any edge.
    @(posedge clk);
    #2;
    amostra_valida = 1'b1;
    amostra        = 4'd7;
    reset          = 1'b0;
    #1 check_zero("async_mid_cycle");
    @(negedge clk);
    check_zero("reset_dominates_valid");
    amostra_valida = 1'b0;
    reset          = 1'b1;

    // After reset: 8 enters SYNC, 7 is an inconsistent step (count=1), lock going down.
    add(1, 8, 0, 0, 0, 0, 0, 0, 0);
    add(1, 7, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 4; k >= 1; k--) add(1, k, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 1, 0);
    for (int k = 1; k <= 7; k++) add(1, k, 1, 0, 0, 0, 0, 1, 0);
    // Skip from 7 to 9, then relock after three consistent steps.
    add(1, 9,  0, 0, 0, 0, 1, 1, 1);
    add(1, 10, 0, 0, 0, 0, 0, 1, 1);
    add(1, 11, 0, 0, 0, 0, 0, 1, 1);
    add(1, 12, 1, 0, 0, 0, 0, 1, 1);
    add(1, 13, 1, 0, 0, 0, 0, 1, 1);
    add(1, 14, 1, 0, 0, 0, 0, 1, 1);
    add(1, 15, 1, 0, 1, 0, 0, 1, 1);
    // Wrap 15 -> 0 is a violation: no valley, ciclos unchanged.
    add(1, 0, 0, 0, 0, 0, 1, 1, 2);
    add(1, 1, 0, 0, 0, 0, 0, 1, 2);
    add(1, 2, 0, 0, 0, 0, 0, 1, 2);
    add(1, 3, 1, 0, 0, 0, 0, 1, 2);
    add(1, 4, 1, 0, 0, 0, 0, 1, 2);
    add(1, 5, 1, 0, 0, 0, 0, 1, 2);
    // Six idle cycles with garbage on amostra, then the expected 6.
    for (int k = 0; k < 6; k++) add(0, 0, 1, 0, 0, 0, 0, 1, 2);
    add(1, 6, 1, 0, 0, 0, 0, 1, 2);
    run_vecs("relock");

    reset = 1'b0;
    @(negedge clk);
    check_zero("reset2");
    reset = 1'b1;

    // Five violations (repeated samples) with a relock between each; ERRW=2 saturates.
    add(1, 5,  0, 0, 0, 0, 0, 0, 0);
    add(1, 6,  0, 0, 0, 0, 0, 0, 0);
    add(1, 7,  0, 0, 0, 0, 0, 0, 0);
    add(1, 8,  1, 0, 0, 0, 0, 0, 0);
    add(1, 8,  0, 0, 0, 0, 1, 0, 1);
    add(1, 9,  0, 0, 0, 0, 0, 0, 1);
    add(1, 10, 0, 0, 0, 0, 0, 0, 1);
    add(1, 11, 1, 0, 0, 0, 0, 0, 1);
    add(1, 11, 0, 0, 0, 0, 1, 0, 2);
    add(1, 12, 0, 0, 0, 0, 0, 0, 2);
    add(1, 13, 0, 0, 0, 0, 0, 0, 2);
    add(1, 14, 1, 0, 0, 0, 0, 0, 2);
    add(1, 14, 0, 0, 0, 0, 1, 0, 3);
    add(1, 15, 0, 0, 0, 0, 0, 0, 3);
    add(1, 14, 0, 0, 0, 0, 0, 0, 3);
    add(1, 13, 1, 1, 0, 0, 0, 0, 3);
    add(1, 13, 0, 1, 0, 0, 1, 0, 4);
    add(1, 12, 0, 1, 0, 0, 0, 0, 4);
    add(1, 11, 0, 1, 0, 0, 0, 0, 4);
    add(1, 10, 1, 1, 0, 0, 0, 0, 4);
    add(1, 10, 0, 1, 0, 0, 1, 0, 5);
    run_vecs("saturation");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/monitor_contador.md
Name: monitor_contador

Overview:
- Receiving-end checker for the 4-bit up/down bouncing counter stream: 0,1,…,15,14,…,0,1,…
- Samples the stream, locks onto the triangle sequence and reports direction, peak/valley events, completed periods and discontinuities.
- Sits downstream of the counter, or of any link carrying it, as a sequence monitor/decoder.

Parameters:
- WIDTH, 4, sample width; MAXV = 2^WIDTH-1.
- LOCK_COUNT, 3, consecutive consistent legal steps required to lock (1..15).
- ERRW, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- amostra_valida  input  1  sample qualifier; amostra is consumed only when 1.
- amostra  input  WIDTH  incoming counter value.
- travado  output  1  locked to the triangle sequence.
- direcao  output  1  current direction: 0 = up, 1 = down.
- pico  output  1  one-cycle pulse when an accepted sample equals MAXV while locked.
- vale  output  1  one-cycle pulse when an accepted sample equals 0 while locked.
- erro  output  1  one-cycle pulse on a sequence violation while locked.
- ciclos  output  16  completed periods (valley-to-valley), wraps mod 2^16.
- erros  output  ERRW  violation count, saturates at 2^ERRW-1.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - All outputs 0.
  - State IDLE; internal prev, step count and last-direction cleared.
  - Reset dominates every other input.
- Accepted sample: amostra_valida=1 at a rising clk edge. With amostra_valida=0, state and counters hold and pulses are 0.
- All outputs registered. Effects of an accepted sample appear 1 cycle after the accepting edge. Pulses last exactly 1 cycle.
- Legal step: |amostra - prev| == 1 with no wrap (15->0 and 0->15 are illegal; equal values are illegal).
  - Step direction: up if amostra > prev, else down.
- Consistent step: legal, and its direction equals the previous step direction, or prev was an endpoint (MAXV or 0).
- States:
  - IDLE: first accepted sample loads prev -> SYNC, count = 0.
  - SYNC (travado=0, no erro pulses):
    - Consistent step: count+1.
    - Legal but inconsistent step: count = 1, adopt new direction.
    - Illegal step: count = 0.
    - prev <= amostra on every accepted sample.
    - count reaching LOCK_COUNT -> LOCKED; travado=1 and direcao = step direction on the same registered update.
  - LOCKED:
    - Expected value up: prev+1, or MAXV-1 with direction flip when prev==MAXV.
    - Expected value down: prev-1, or 1 with direction flip when prev==0.
    - Match: update prev and direcao. pico if amostra==MAXV; vale if amostra==0. ciclos+1 on each vale.
    - Mismatch: erro=1, erros+1 (saturating), travado=0 -> SYNC with prev = amostra, count = 0. No pico/vale/ciclos on a mismatched sample, even if its value is 0 or MAXV.
- pico/vale/ciclos update only in LOCKED and only on matching samples.
- direcao holds its last value while unlocked.
- Relock always requires LOCK_COUNT fresh consistent steps.
- ciclos wraps 0xFFFF->0. erros stops at all-ones.
- Back-to-back valid samples every cycle are supported at full rate.

Test Plan:
1. Reset, then valid every cycle with 0,1,…,15,14,…,0,1 -> travado rises 1 cycle after sample 3 is accepted; direcao flips to 1 after sample 15 is followed by 14; pico exactly once (at 15); vale at the final 0; ciclos=1; erro never asserted.
2. Locked, counting up at 7, inject 9, then 10,11,12 -> erro pulse 1 cycle after 9 is accepted; erros=1; travado=0; travado back to 1 after sample 12 (3 consistent steps); ciclos unchanged.
3. Locked at 15 going up, inject 0 (wrap) -> erro pulse, erros+1; no vale, ciclos unchanged, even though the sample is 0.
4. Locked mid-ramp at 5, amostra_valida=0 for 6 cycles while amostra toggles random values, then 6 -> no pulses, outputs held during the gap, 6 accepted as a match, travado stays 1.
5. ERRW=2, five violations while relocking between each -> erros = 1,2,3,3,3.
6. Assert reset between clock edges while locked with ciclos=4 -> all outputs 0 immediately, before the next edge; after release, first sample 8 enters SYNC, travado=0.
